// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ext_pipe
//  Purpose  : Immediate / load-data extender feeding a DEPTH-entry result queue
//             with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int OFF_W = $clog2(OUT_W / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [IN_W-1:0]  imm,
    input  logic [OUT_W-1:0] data,
    input  logic [OFF_W-1:0] offset,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_misalign
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = DEPTH;
    localparam logic [2:0]         c_M_ZEXT   = 3'd0;
    localparam logic [2:0]         c_M_SEXT   = 3'd1;
    localparam logic [2:0]         c_M_HIGH   = 3'd2;
    localparam logic [2:0]         c_M_BRANCH = 3'd3;
    localparam logic [2:0]         c_M_LBS    = 3'd4;
    localparam logic [2:0]         c_M_LBU    = 3'd5;
    localparam logic [2:0]         c_M_LHS    = 3'd6;
    localparam logic [2:0]         c_M_LHU    = 3'd7;

    logic [OUT_W-1:0]   w_sext;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [OUT_W-1:0]   w_result;
    logic               w_misalign;
    logic               w_push;
    logic               w_pop;

    logic [OUT_W-1:0]   r_mem_data [DEPTH];
    logic               r_mem_mis  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Half-word select ignores offset[0]; a set bit 0 only raises the misalign flag.
    assign w_sext = {{(OUT_W - IN_W){imm[IN_W-1]}}, imm};
    assign w_byte = data[{offset, 3'b000} +: 8];
    assign w_half = data[{offset[OFF_W-1:1], 4'b0000} +: 16];

    always_comb begin
        w_result   = '0;
        w_misalign = 1'b0;
        case (mode)
            c_M_ZEXT:   w_result = {{(OUT_W - IN_W){1'b0}}, imm};
            c_M_SEXT:   w_result = w_sext;
            c_M_HIGH:   w_result = {imm, {(OUT_W - IN_W){1'b0}}};
            c_M_BRANCH: w_result = {w_sext[OUT_W-3:0], 2'b00};
            c_M_LBS:    w_result = {{(OUT_W - 8){w_byte[7]}}, w_byte};
            c_M_LBU:    w_result = {{(OUT_W - 8){1'b0}}, w_byte};
            c_M_LHS: begin
                w_result   = {{(OUT_W - 16){w_half[15]}}, w_half};
                w_misalign = offset[0];
            end
            c_M_LHU: begin
                w_result   = {{(OUT_W - 16){1'b0}}, w_half};
                w_misalign = offset[0];
            end
            default: w_result = '0;
        endcase
    end

    assign in_ready  = (r_count < c_CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Storage is left unreset; the empty-queue gate keeps the outputs clean.
    assign out_data     = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_misalign = out_valid ? r_mem_mis[r_rd_ptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_data[r_wr_ptr] <= w_result;
            r_mem_mis[r_wr_ptr]  <= w_misalign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_pipe
//  Purpose  : Directed self-checking bench for ext_pipe (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ext_pipe;

    localparam int c_IN_W  = 16;
    localparam int c_OUT_W = 32;
    localparam int c_DEPTH = 2;
    localparam int c_OFF_W = 2;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         mode;
    logic [c_IN_W-1:0]  imm;
    logic [c_OUT_W-1:0] data;
    logic [c_OFF_W-1:0] offset;
    logic               out_valid;
    logic               out_ready;
    logic [c_OUT_W-1:0] out_data;
    logic               out_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    ext_pipe #(
        .IN_W  (c_IN_W),
        .OUT_W (c_OUT_W),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode         (mode),
        .imm          (imm),
        .data         (data),
        .offset       (offset),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [15:0] i,
                         input logic [31:0] d, input logic [1:0] o);
        mode     = m;
        imm      = i;
        data     = d;
        offset   = o;
        in_valid = 1'b1;
    endtask

    // One request accepted at the next edge; its result must be at the head right after.
    task automatic xfer(input string tag, input logic [2:0] m, input logic [15:0] i,
                        input logic [31:0] d, input logic [1:0] o,
                        input logic [31:0] exp_d, input logic exp_mis);
        drive(m, i, d, o);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check({tag, "_mis"}, 64'(out_misalign), 64'(exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = '0;
        imm       = '0;
        data      = '0;
        offset    = '0;
        #22;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mis", 64'(out_misalign), 64'd0);
        rst_n = 1'b1;
        tick();

        // Extension modes, back to back with out_ready=1
        xfer("m1_sext",   3'd1, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
        xfer("m0_zext",   3'd0, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
        xfer("m2_high",   3'd2, 16'h8001, 32'h0, 2'd1, 32'h80010000, 1'b0);
        xfer("m1_pos",    3'd1, 16'h7FFF, 32'h0, 2'd3, 32'h00007FFF, 1'b0);
        xfer("m3_neg1",   3'd3, 16'hFFFF, 32'h0, 2'd0, 32'hFFFFFFFC, 1'b0);
        xfer("m3_four",   3'd3, 16'h0004, 32'h0, 2'd0, 32'h00000010, 1'b0);
        xfer("m3_min",    3'd3, 16'h8000, 32'h0, 2'd1, 32'hFFFE0000, 1'b0);
        xfer("m4_off2",   3'd4, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
        xfer("m4_off1",   3'd4, 16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
        xfer("m5_off3",   3'd5, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
        xfer("m5_off0",   3'd5, 16'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
        xfer("m6_off2",   3'd6, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
        xfer("m6_off0",   3'd6, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
        xfer("m6_off3",   3'd6, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFF80FF, 1'b1);
        xfer("m7_off1",   3'd7, 16'h0, 32'h80FF7F01, 2'd1, 32'h00007F01, 1'b1);
        xfer("m7_off3",   3'd7, 16'h0, 32'h80FF7F01, 2'd3, 32'h000080FF, 1'b1);
        xfer("m7_off2",   3'd7, 16'h0, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_data", 64'(out_data), 64'd0);

        // Backpressure: three requests into a two-entry queue
        out_ready = 1'b0;
        drive(3'd0, 16'h1111, 32'h0, 2'd0);
        tick();
        check("bp_ready_1", 64'(in_ready), 64'd1);
        check("bp_head_1", 64'(out_data), 64'h00001111);
        drive(3'd1, 16'h8222, 32'h0, 2'd0);
        tick();
        check("bp_ready_full", 64'(in_ready), 64'd0);
        drive(3'd2, 16'h3333, 32'h0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_stall_ready", 64'(in_ready), 64'd0);
            check("bp_stall_data", 64'(out_data), 64'h00001111);
        end
        out_ready = 1'b1;
        tick();
        check("bp_pop_a_ready", 64'(in_ready), 64'd1);
        check("bp_head_b", 64'(out_data), 64'hFFFF8222);
        tick();
        in_valid = 1'b0;
        check("bp_head_c", 64'(out_data), 64'h33330000);
        check("bp_head_c_valid", 64'(out_valid), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Steady push+pop with one entry resident; pointers wrap several times
        drive(3'd0, 16'h0A00, 32'h0, 2'd0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(3'd0, 16'(16'h0A00 + k), 32'h0, 2'd0);
            tick();
            check("st_data", 64'(out_data), 64'(32'h00000A00 + k));
            check("st_ready", 64'(in_ready), 64'd1);
            check("st_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("st_empty", 64'(out_valid), 64'd0);

        // Flush with a full queue and a pending request
        out_ready = 1'b0;
        drive(3'd0, 16'h0001, 32'h0, 2'd0);
        tick();
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        // Flush with one entry and a push that must be discarded
        tick();
        check("fl2_one", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 64'(out_valid), 64'd0);
        check("fl2_data", 64'(out_data), 64'd0);

        // Asynchronous reset mid-cycle with an entry queued
        drive(3'd1, 16'hC000, 32'h0, 2'd0);
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        check("ar_pre_data", 64'(out_data), 64'hFFFFC000);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        check("ar_data", 64'(out_data), 64'd0);
        #3;
        rst_n = 1'b1;
        drive(3'd2, 16'h00FF, 32'h0, 2'd0);
        tick();
        in_valid = 1'b0;
        check("ar_first_valid", 64'(out_valid), 64'd1);
        check("ar_first_data", 64'(out_data), 64'h00FF0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the datapath extender.
- Takes an immediate, or a loaded data word plus byte offset, and applies one of 8 extension modes.
- Results pass through a DEPTH-entry result queue with valid/ready handshakes on both sides.
- Sits between decode/memory-return and the execute/writeback mux, so upstream and downstream stalls decouple.

Parameters:
- IN_W, 16: immediate width.
- OUT_W, 32: result and data width; multiple of 16; OUT_W > IN_W.
- DEPTH, 2: result queue entries; DEPTH >= 2, power of two.
- OFF_W, $clog2(OUT_W/8): byte-offset width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous queue clear
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- mode  in  3  extension mode (see Behaviour)
- imm  in  IN_W  immediate operand (modes 0-3)
- data  in  OUT_W  load data word (modes 4-7)
- offset  in  OFF_W  byte offset within data (modes 4-7)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  OUT_W  extended result
- out_misalign  out  1  half-word access with odd offset

Behaviour:
- Modes:
  - 0 zero-extend imm.
  - 1 sign-extend imm[IN_W-1].
  - 2 high: imm placed at [OUT_W-1:OUT_W-IN_W], low bits 0.
  - 3 branch: sign-extend imm, then shift left 2; bits shifted out are dropped.
  - 4 byte signed: byte = data[8*offset+:8], sign-extended.
  - 5 byte unsigned: same byte, zero-extended.
  - 6 half signed: half = data[16*offset[OFF_W-1:1]+:16], sign-extended.
  - 7 half unsigned: same half, zero-extended.
- offset is ignored in modes 0-3.
- Misalignment:
  - Modes 6/7 with offset[0]=1: out_misalign=1 for that entry; data uses offset with bit 0 cleared.
  - out_misalign=0 for all other modes.
- Result is computed combinationally at acceptance; {result, misalign} is stored in the queue.
- Latency: accept at edge N -> out_valid=1 after edge N (visible in cycle N+1) if the queue was empty. No combinational in->out path.
- Queue: count 0..DEPTH, circular read/write pointers wrapping at DEPTH.
  - in_ready = (count < DEPTH). Registered-equivalent: depends only on count, not on out_ready.
  - out_valid = (count != 0). out_data and out_misalign come from the head entry; they hold stable while out_valid & !out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, a same-cycle pop does not enable a push (in_ready already 0).
  - Pop when empty and push when full cannot occur by construction.
- flush: count=0 and pointers=0 at the edge. A push in the same cycle is discarded. flush has priority over push and pop.
- Reset (rst_n=0, asynchronous):
  - count=0, pointers=0.
  - out_valid=0, in_ready=1 (from count), out_data=0, out_misalign=0.
  - Queue storage need not reset, but out_data must read 0 while empty after reset.
  - Reset mid-transfer drops all entries. First valid acceptance is at the first rising edge with rst_n=1.
- No X on outputs while out_valid=0 after reset (drive head entry or 0).

Test Plan:
- Reset, then imm=16'h8001 mode 1, out_ready=1 -> out_valid next cycle, out_data=32'hFFFF8001. Mode 0 same imm -> 32'h00008001. Mode 2 -> 32'h80010000.
- Mode 3 imm=16'hFFFF -> 32'hFFFFFFFC. Mode 3 imm=16'h0004 -> 32'h00000010.
- data=32'h80FF7F01: mode 4 offset 2 -> 32'hFFFFFFFF. Mode 5 offset 3 -> 32'h00000080. Mode 6 offset 2 -> 32'hFFFF80FF, misalign=0. Mode 7 offset 1 -> 32'h00007F01, misalign=1.
- out_ready=0, push 3 requests (DEPTH=2) -> in_ready=0 after 2nd acceptance, 3rd held. Raise out_ready -> results emerge in order, count never exceeds 2, out_data stable while stalled.
- Queue holding 1 entry, simultaneous push+pop each cycle for 8 cycles -> count stays 1, pointer wrap correct, outputs in order.
- flush asserted with in_valid=1 and 2 entries queued -> next cycle out_valid=0, in_ready=1. Assert rst_n=0 mid-cycle -> out_valid=0 immediately, with no clock edge.
